decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WIDTH, default 32, instruction/data width; legal values ≥ 32.
REQ-002 Parameter REG_SEL, default 5, register address width; each bank holds 2^REG_SEL registers.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid / in_ready  input / output  1 / 1  instruction handshake; transfer when both are high.
REQ-006 in_inst  input  WIDTH  instruction word.
REQ-007 flush  input  1  discard the held output instruction.
REQ-008 out_valid / out_ready  output / input  1 / 1  decoded-bundle handshake.
REQ-009 out_opcode  output  5  inst[WIDTH-1:WIDTH-5].
REQ-010 out_is_branch, out_halted, out_z_writes  output  1 each  decoded flags.
REQ-011 out_cc  output  3  compare condition.
REQ-012 out_a_sel, out_a_from_rb, out_b_sel, out_b_from_rb, out_z_sel  output  1 each  bank selects (S_REGS/P_REGS) and register-vs-immediate flags.
REQ-013 out_a_addr, out_b_addr, out_z_addr  output  REG_SEL each  register addresses.
REQ-014 out_a_data, out_b_data  output  WIDTH each  immediates.
REQ-015 wb_valid  input  1;  wb_sel  input  1;  wb_addr  input  REG_SEL  writeback retire (clears a pending write).
REQ-016 halt_latched  output  1  set after a HALT is accepted.

Function
REQ-017 Decode is registered: an instruction accepted in cycle N appears on out_* with out_valid=1 in cycle N+1.
REQ-018 ALU class is ADD, SUB, MPY, AND, OR, XOR, SHL, SRL, SRA, CMP.
REQ-019 Large immediate applies to MOV and BR.
REQ-020 Small immediate applies when ALU and inst[WIDTH-6]=1; it is sign-extended when inst[WIDTH-7]=1, else zero-extended, from inst[REG_SEL-1:0] to WIDTH.
REQ-021 A field rules: a_sel=P_REGS for BR, else S_REGS.
REQ-022 a_addr = zero-extended inst[19:16] for BR; 0 for MOV; else inst[9:5].
REQ-023 a_data = inst[15:0] sign-extended to WIDTH.
REQ-024 a_from_rb = not large-immediate.
REQ-025 B field rules: b_sel=S_REGS always.
REQ-026 b_addr = 0 for large-immediate; else inst[4:0].
REQ-027 b_from_rb = neither large nor small immediate.
REQ-028 b_data = small immediate, else 0.
REQ-029 Z field rules: z_sel=P_REGS for CMP, else S_REGS.
REQ-030 z_addr = 0 for BR; else inst[20:16].
REQ-031 z_writes = ALU or MOV.
REQ-032 out_cc = inst[12:10] for CMP, else 3'b000; no high-impedance outputs.
REQ-033 Output holds stable while out_valid=1 and out_ready=0.
REQ-034 Scoreboard: one busy bit per register per bank.
REQ-035 A busy bit is set on output handshake when z_writes=1.
REQ-036 A busy bit is cleared by wb_valid; set wins over clear on the same register in the same cycle.
REQ-037 Hazard: a sourced register (a if a_from_rb, b if b_from_rb) or the z target is busy, or matches the z of a valid, writing output-register instruction.
REQ-038 in_ready = !rst & !halt_latched & !flush & !hazard & (!out_valid | out_ready).
REQ-039 Hazard checks read registered busy state, so a writeback clearing a bit unblocks acceptance the following cycle.
REQ-040 flush clears out_valid the next cycle, blocks acceptance that cycle, and leaves the scoreboard unchanged; flush has priority over out_ready.
REQ-041 Accepting HALT sets halt_latched; HALT itself is emitted with out_halted=1; no further acceptance occurs until reset.

Reset
REQ-042 rst clears out_valid, halt_latched and all busy bits, and zeros every out_* field; rst mid-transfer drops the held bundle.

Structure
REQ-043 Opcode constants, S_REGS/P_REGS and field positions live in the shared defines package.
REQ-044 Combinational field decode is a sub-module decode_fields, instantiated once, parametrised by WIDTH and REG_SEL.

Verification
REQ-045 ADD r3,r1,r2 (0x...) → next cycle out_valid=1, a_addr=1, b_addr=2, z_addr=3, z_writes=1, busy[S][3]=1 after handshake.
REQ-046 SUB with inst[26]=1, inst[25]=1, inst[4:0]=5'b11110 → b_from_rb=0, b_data=0xFFFFFFFE.
REQ-047 Write r3, then read r3 → in_ready=0 until wb_valid with wb_addr=3, then in_ready=1 one cycle later.
REQ-048 out_ready=0 for 3 cycles with valid bundle → outputs stable, in_ready=0.
REQ-049 flush asserted with bundle held → out_valid=0 next cycle, busy bits unchanged.
REQ-050 HALT accepted → out_halted=1, halt_latched=1, in_ready=0 until rst; rst clears all state.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode encoding, register bank
// identifiers and instruction field positions.
package decode_stage_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MPY  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SHL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,
    OP_CMP  = 5'd9,
    OP_MOV  = 5'd10,
    OP_BR   = 5'd11,
    OP_HALT = 5'd12,
    OP_NOP  = 5'd13
  } opcode_e;

  // Register bank identifiers
  localparam logic S_REGS = 1'b0;
  localparam logic P_REGS = 1'b1;

  // Opcode occupies the top OPC_W bits of the word
  localparam int OPC_W     = 5;
  // Small-immediate enable and sign bits, as offsets below WIDTH
  localparam int SMALL_OFS = 6;
  localparam int SIGN_OFS  = 7;

  // Fixed low-order field positions
  localparam int R_W      = 5;   // register field width in the encoding
  localparam int Z_LSB    = 16;
  localparam int A_LSB    = 5;
  localparam int B_LSB    = 0;
  localparam int BR_A_LSB = 16;  // branch source register (P bank)
  localparam int BR_A_W   = 4;
  localparam int CC_LSB   = 10;
  localparam int CC_W     = 3;
  localparam int IMM_W    = 16;

  // ALU-class membership: only these opcodes may carry a small immediate
  function automatic logic is_alu(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SRL, OP_SRA, OP_CMP: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// Purely combinational field decode of one instruction word into the
// operand/target bundle consumed by the decode stage register.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_SEL = 5
) (
  input  logic [WIDTH-1:0]   inst,
  output logic [OPC_W-1:0]   opcode,
  output logic               is_branch,
  output logic               halted,
  output logic               z_writes,
  output logic [CC_W-1:0]    cc,
  output logic               a_sel,
  output logic               a_from_rb,
  output logic               b_sel,
  output logic               b_from_rb,
  output logic               z_sel,
  output logic [REG_SEL-1:0] a_addr,
  output logic [REG_SEL-1:0] b_addr,
  output logic [REG_SEL-1:0] z_addr,
  output logic [WIDTH-1:0]   a_data,
  output logic [WIDTH-1:0]   b_data
);

  opcode_e            op;
  logic               alu;
  logic               large_imm;
  logic               small_imm;
  logic [REG_SEL-1:0] imm_raw;
  logic [WIDTH-1:0]   small_val;
  logic               unused_inst_bits;

  assign op        = opcode_e'(inst[WIDTH-1 -: OPC_W]);
  assign alu       = is_alu(op);
  assign large_imm = (op == OP_MOV) || (op == OP_BR);
  assign small_imm = alu && inst[WIDTH-SMALL_OFS];
  assign imm_raw   = inst[REG_SEL-1:0];

  // Bits between the immediate-mode flags and the Z field carry no meaning
  assign unused_inst_bits = ^inst[WIDTH-SIGN_OFS-1 : Z_LSB+R_W];

  // Small immediate: sign- or zero-extend the low register field
  always_comb begin
    if (inst[WIDTH-SIGN_OFS]) small_val = {{(WIDTH-REG_SEL){imm_raw[REG_SEL-1]}}, imm_raw};
    else                      small_val = {{(WIDTH-REG_SEL){1'b0}}, imm_raw};
  end

  // Per-field decode rules for the A, B and Z operands and the flags
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    opcode    = inst[WIDTH-1 -: OPC_W];
    is_branch = (op == OP_BR);
    halted    = (op == OP_HALT);
    z_writes  = alu || (op == OP_MOV);
    cc        = '0;
    a_sel     = S_REGS;
    a_from_rb = !large_imm;
    b_sel     = S_REGS;
    b_from_rb = !(large_imm || small_imm);
    z_sel     = S_REGS;
    a_addr    = REG_SEL'(inst[A_LSB +: R_W]);
    b_addr    = REG_SEL'(inst[B_LSB +: R_W]);
    z_addr    = REG_SEL'(inst[Z_LSB +: R_W]);
    a_data    = {{(WIDTH-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
    b_data    = '0;

    if (op == OP_BR) begin
      a_sel  = P_REGS;
      a_addr = REG_SEL'(inst[BR_A_LSB +: BR_A_W]);
      z_addr = '0;
    end else if (op == OP_MOV) begin
      a_addr = '0;
    end

    if (large_imm) b_addr = '0;
    if (small_imm) b_data = small_val;

    if (op == OP_CMP) begin
      z_sel = P_REGS;
      cc    = inst[CC_LSB +: CC_W];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a per-register busy scoreboard for two
// register banks, RAW/WAW hazard stalling, flush and sticky halt.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_SEL = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_inst,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_opcode,
  output logic               out_is_branch,
  output logic               out_halted,
  output logic               out_z_writes,
  output logic [2:0]         out_cc,
  output logic               out_a_sel,
  output logic               out_a_from_rb,
  output logic               out_b_sel,
  output logic               out_b_from_rb,
  output logic               out_z_sel,
  output logic [REG_SEL-1:0] out_a_addr,
  output logic [REG_SEL-1:0] out_b_addr,
  output logic [REG_SEL-1:0] out_z_addr,
  output logic [WIDTH-1:0]   out_a_data,
  output logic [WIDTH-1:0]   out_b_data,
  input  logic               wb_valid,
  input  logic               wb_sel,
  input  logic [REG_SEL-1:0] wb_addr,
  output logic               halt_latched
);

  localparam int NREG = 1 << REG_SEL;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic               is_branch;
    logic               halted;
    logic               z_writes;
    logic [CC_W-1:0]    cc;
    logic               a_sel;
    logic               a_from_rb;
    logic               b_sel;
    logic               b_from_rb;
    logic               z_sel;
    logic [REG_SEL-1:0] a_addr;
    logic [REG_SEL-1:0] b_addr;
    logic [REG_SEL-1:0] z_addr;
    logic [WIDTH-1:0]   a_data;
    logic [WIDTH-1:0]   b_data;
  } bundle_t;

  bundle_t               dec;
  bundle_t               bundle_d, bundle_q;
  logic                  out_valid_d, out_valid_q;
  logic                  halt_latched_d, halt_latched_q;
  logic [1:0][NREG-1:0]  busy_d, busy_q;
  logic [1:0][NREG-1:0]  set_mask, clr_mask;
  logic                  out_wr;
  logic                  hazard;
  logic                  in_fire;
  logic                  out_fire;

  decode_fields #(
    .WIDTH   (WIDTH),
    .REG_SEL (REG_SEL)
  ) u_fields (
    .inst      (in_inst),
    .opcode    (dec.opcode),
    .is_branch (dec.is_branch),
    .halted    (dec.halted),
    .z_writes  (dec.z_writes),
    .cc        (dec.cc),
    .a_sel     (dec.a_sel),
    .a_from_rb (dec.a_from_rb),
    .b_sel     (dec.b_sel),
    .b_from_rb (dec.b_from_rb),
    .z_sel     (dec.z_sel),
    .a_addr    (dec.a_addr),
    .b_addr    (dec.b_addr),
    .z_addr    (dec.z_addr),
    .a_data    (dec.a_data),
    .b_data    (dec.b_data)
  );

  // The held bundle still counts as an in-flight writer until it hands off
  assign out_wr = out_valid_q && bundle_q.z_writes;

  // Hazard: any register the incoming instruction touches is pending a write
  always_comb begin
    hazard = 1'b0;
    if (dec.a_from_rb &&
        (busy_q[dec.a_sel][dec.a_addr] ||
         (out_wr && bundle_q.z_sel == dec.a_sel && bundle_q.z_addr == dec.a_addr)))
      hazard = 1'b1;
    if (dec.b_from_rb &&
        (busy_q[dec.b_sel][dec.b_addr] ||
         (out_wr && bundle_q.z_sel == dec.b_sel && bundle_q.z_addr == dec.b_addr)))
      hazard = 1'b1;
    if (dec.z_writes &&
        (busy_q[dec.z_sel][dec.z_addr] ||
         (out_wr && bundle_q.z_sel == dec.z_sel && bundle_q.z_addr == dec.z_addr)))
      hazard = 1'b1;
  end

  assign in_ready = !rst && !halt_latched_q && !flush && !hazard &&
                    (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  // Flush wins over out_ready: a flushed bundle never counts as delivered
  assign out_fire = out_valid_q && out_ready && !flush;

  // Scoreboard set on delivery of a writing bundle, clear on writeback retire
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (out_fire && bundle_q.z_writes) set_mask[bundle_q.z_sel][bundle_q.z_addr] = 1'b1;
    if (wb_valid)                      clr_mask[wb_sel][wb_addr]                 = 1'b1;
  end

  // Next-state for the output register, scoreboard and halt flag
  always_comb begin
    bundle_d       = bundle_q;
    out_valid_d    = out_valid_q;
    halt_latched_d = halt_latched_q;
    // Set is applied after clear so a same-cycle set on that register wins
    busy_d         = (busy_q & ~clr_mask) | set_mask;

    if (flush || out_fire) out_valid_d = 1'b0;

    if (in_fire) begin
      bundle_d    = dec;
      out_valid_d = 1'b1;
      if (dec.halted) halt_latched_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      bundle_q       <= '0;
      out_valid_q    <= 1'b0;
      halt_latched_q <= 1'b0;
      // NOTE: the scoreboard is built from discrete flops rather than a RAM,
      // so the whole array can be cleared by reset in a single cycle.
      busy_q         <= '0;
    end else begin
      bundle_q       <= bundle_d;
      out_valid_q    <= out_valid_d;
      halt_latched_q <= halt_latched_d;
      busy_q         <= busy_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign halt_latched  = halt_latched_q;
  assign out_opcode    = bundle_q.opcode;
  assign out_is_branch = bundle_q.is_branch;
  assign out_halted    = bundle_q.halted;
  assign out_z_writes  = bundle_q.z_writes;
  assign out_cc        = bundle_q.cc;
  assign out_a_sel     = bundle_q.a_sel;
  assign out_a_from_rb = bundle_q.a_from_rb;
  assign out_b_sel     = bundle_q.b_sel;
  assign out_b_from_rb = bundle_q.b_from_rb;
  assign out_z_sel     = bundle_q.z_sel;
  assign out_a_addr    = bundle_q.a_addr;
  assign out_b_addr    = bundle_q.b_addr;
  assign out_z_addr    = bundle_q.z_addr;
  assign out_a_data    = bundle_q.a_data;
  assign out_b_data    = bundle_q.b_data;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus handwritten
// hazard, stall, flush, reset and halt sequences, with an output scoreboard.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  opcode;
    logic        is_branch;
    logic        halted;
    logic        z_writes;
    logic [2:0]  cc;
    logic        a_sel;
    logic        a_from_rb;
    logic        b_sel;
    logic        b_from_rb;
    logic        z_sel;
    logic [4:0]  a_addr;
    logic [4:0]  b_addr;
    logic [4:0]  z_addr;
    logic [31:0] a_data;
    logic [31:0] b_data;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    exp_t        exp;
  } vec_t;

  localparam int NV = 9;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [4:0]  out_opcode;
  logic        out_is_branch, out_halted, out_z_writes;
  logic [2:0]  out_cc;
  logic        out_a_sel, out_a_from_rb, out_b_sel, out_b_from_rb, out_z_sel;
  logic [4:0]  out_a_addr, out_b_addr, out_z_addr;
  logic [31:0] out_a_data, out_b_data;
  logic        wb_valid, wb_sel;
  logic [4:0]  wb_addr;
  logic        halt_latched;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  decode_stage #(.WIDTH(32), .REG_SEL(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_is_branch (out_is_branch),
    .out_halted    (out_halted),
    .out_z_writes  (out_z_writes),
    .out_cc        (out_cc),
    .out_a_sel     (out_a_sel),
    .out_a_from_rb (out_a_from_rb),
    .out_b_sel     (out_b_sel),
    .out_b_from_rb (out_b_from_rb),
    .out_z_sel     (out_z_sel),
    .out_a_addr    (out_a_addr),
    .out_b_addr    (out_b_addr),
    .out_z_addr    (out_z_addr),
    .out_a_data    (out_a_data),
    .out_b_data    (out_b_data),
    .wb_valid      (wb_valid),
    .wb_sel        (wb_sel),
    .wb_addr       (wb_addr),
    .halt_latched  (halt_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Register-form encoding: op | small | sign | 0000 | z | 000 | cc | a | b
  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic sm, input logic sg,
                                         input logic [4:0] z, input logic [2:0] cc,
                                         input logic [4:0] a, input logic [4:0] b);
    return {op, sm, sg, 4'b0000, z, 3'b000, cc, a, b};
  endfunction

  // Immediate-form encoding: op | 000000 | z | imm16
  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] z,
                                         input logic [15:0] imm);
    return {op, 6'b000000, z, imm};
  endfunction

  // flags = {is_branch, halted, z_writes}; sels = {a_sel, a_from_rb, b_sel, b_from_rb, z_sel}
  function automatic exp_t mk(input logic [4:0] op, input logic [2:0] flags, input logic [2:0] cc,
                              input logic [4:0] sels, input logic [4:0] aa, input logic [4:0] ba,
                              input logic [4:0] za, input logic [31:0] ad, input logic [31:0] bd);
    exp_t e;
    e.opcode    = op;
    e.is_branch = flags[2];
    e.halted    = flags[1];
    e.z_writes  = flags[0];
    e.cc        = cc;
    e.a_sel     = sels[4];
    e.a_from_rb = sels[3];
    e.b_sel     = sels[2];
    e.b_from_rb = sels[1];
    e.z_sel     = sels[0];
    e.a_addr    = aa;
    e.b_addr    = ba;
    e.z_addr    = za;
    e.a_data    = ad;
    e.b_data    = bd;
    return e;
  endfunction

  // Plain register ADD z <- a, b: a_data is the low 16 bits {000,000,a,b}
  function automatic exp_t exp_add(input logic [4:0] z, input logic [4:0] a, input logic [4:0] b);
    return mk(OP_ADD, 3'b001, 3'd0, 5'b01010, a, b, z, {22'b0, a, b}, 32'h0);
  endfunction

  function automatic exp_t dut_bundle();
    exp_t e;
    e.opcode    = out_opcode;
    e.is_branch = out_is_branch;
    e.halted    = out_halted;
    e.z_writes  = out_z_writes;
    e.cc        = out_cc;
    e.a_sel     = out_a_sel;
    e.a_from_rb = out_a_from_rb;
    e.b_sel     = out_b_sel;
    e.b_from_rb = out_b_from_rb;
    e.z_sel     = out_z_sel;
    e.a_addr    = out_a_addr;
    e.b_addr    = out_b_addr;
    e.z_addr    = out_z_addr;
    e.a_data    = out_a_data;
    e.b_data    = out_b_data;
    return e;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present an instruction; it must be accepted this cycle
  task automatic offer(input logic [31:0] inst, input exp_t e, input string nm);
    in_valid = 1'b1;
    in_inst  = inst;
    #1;
    check({nm, "_ready"}, in_ready, 1);
    if (in_ready) sb.push_back(e);
  endtask

  // A bundle must be on the output: compare against the scoreboard head
  task automatic expect_out(input string nm);
    exp_t e;
    check({nm, "_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_fields: got bundle with empty scoreboard, expected an entry", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_fields"}, dut_bundle(), e);
    end
  endtask

  task automatic retire(input logic sel, input logic [4:0] addr);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_sel   = sel;
    wb_addr  = addr;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{enc_r(OP_ADD, 0, 0, 5'd3, 3'd0, 5'd1, 5'd2), exp_add(5'd3, 5'd1, 5'd2)};
    vecs[1] = '{enc_r(OP_SUB, 1, 1, 5'd4, 3'd0, 5'd5, 5'b11110),
                mk(OP_SUB, 3'b001, 3'd0, 5'b01000, 5'd5, 5'd30, 5'd4, 32'h0000_00BE, 32'hFFFF_FFFE)};
    vecs[2] = '{enc_r(OP_XOR, 1, 0, 5'd6, 3'd0, 5'd7, 5'd17),
                mk(OP_XOR, 3'b001, 3'd0, 5'b01000, 5'd7, 5'd17, 5'd6, 32'h0000_00F1, 32'h0000_0011)};
    vecs[3] = '{enc_r(OP_CMP, 0, 0, 5'd2, 3'd5, 5'd8, 5'd9),
                mk(OP_CMP, 3'b001, 3'd5, 5'b01011, 5'd8, 5'd9, 5'd2, 32'h0000_1509, 32'h0)};
    vecs[4] = '{enc_i(OP_MOV, 5'd10, 16'h8001),
                mk(OP_MOV, 3'b001, 3'd0, 5'b00000, 5'd0, 5'd0, 5'd10, 32'hFFFF_8001, 32'h0)};
    vecs[5] = '{enc_i(OP_BR, 5'b10111, 16'h1234),
                mk(OP_BR, 3'b100, 3'd0, 5'b10000, 5'd7, 5'd0, 5'd0, 32'h0000_1234, 32'h0)};
    vecs[6] = '{enc_r(OP_NOP, 1, 1, 5'd1, 3'd6, 5'd2, 5'd31),
                mk(OP_NOP, 3'b000, 3'd0, 5'b01010, 5'd2, 5'd31, 5'd1, 32'h0000_185F, 32'h0)};
    vecs[7] = '{enc_r(OP_SRA, 0, 1, 5'd11, 3'd0, 5'd12, 5'd31),
                mk(OP_SRA, 3'b001, 3'd0, 5'b01010, 5'd12, 5'd31, 5'd11, 32'h0000_019F, 32'h0)};
    vecs[8] = '{enc_r(OP_MPY, 1, 1, 5'd13, 3'd0, 5'd14, 5'd15),
                mk(OP_MPY, 3'b001, 3'd0, 5'b01000, 5'd14, 5'd15, 5'd13, 32'h0000_01CF, 32'h0000_000F)};

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_sel = 1'b0; wb_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_halt", halt_latched, 0);
    check("rst_fields", dut_bundle(), exp_t'(0));
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table: one instruction at a time, retired after delivery
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      offer(vecs[i].inst, vecs[i].exp, $sformatf("vec%0d", i));
      @(negedge clk);
      in_valid = 1'b0;
      expect_out($sformatf("vec%0d", i));
      if (vecs[i].exp.z_writes) retire(vecs[i].exp.z_sel, vecs[i].exp.z_addr);
    end

    // RAW hazard on r3 released by writeback one cycle after retire
    @(negedge clk);
    offer(enc_r(OP_ADD, 0, 0, 5'd3, 3'd0, 5'd1, 5'd2), exp_add(5'd3, 5'd1, 5'd2), "haz_w3");
    @(negedge clk);
    in_inst = enc_r(OP_ADD, 0, 0, 5'd5, 3'd0, 5'd3, 5'd4);
    #1;
    check("haz_out_match", in_ready, 0);
    expect_out("haz_w3");
    @(negedge clk); #1;
    check("haz_busy", in_ready, 0);
    @(negedge clk);
    wb_valid = 1'b1; wb_sel = S_REGS; wb_addr = 5'd3;
    #1;
    check("haz_wb_cycle", in_ready, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    offer(enc_r(OP_ADD, 0, 0, 5'd5, 3'd0, 5'd3, 5'd4), exp_add(5'd5, 5'd3, 5'd4), "haz_release");
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("haz_release");
    retire(S_REGS, 5'd5);

    // Set wins over clear when delivery and writeback hit r20 together
    @(negedge clk);
    offer(enc_r(OP_ADD, 0, 0, 5'd20, 3'd0, 5'd1, 5'd2), exp_add(5'd20, 5'd1, 5'd2), "sw_w20");
    @(negedge clk);
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_sel = S_REGS; wb_addr = 5'd20;
    expect_out("sw_w20");
    @(negedge clk);
    wb_valid = 1'b0;
    in_valid = 1'b1; in_inst = enc_r(OP_ADD, 0, 0, 5'd6, 3'd0, 5'd20, 5'd1);
    #1;
    check("set_wins", in_ready, 0);
    in_valid = 1'b0;
    retire(S_REGS, 5'd20);

    // Back-pressure: bundle holds for 3 cycles, nothing accepted
    @(negedge clk);
    out_ready = 1'b0;
    offer(enc_r(OP_OR, 0, 0, 5'd15, 3'd0, 5'd16, 5'd17),
          mk(OP_OR, 3'b001, 3'd0, 5'b01010, 5'd16, 5'd17, 5'd15, 32'h0000_0211, 32'h0), "stall");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_inst = enc_r(OP_AND, 0, 0, 5'd18, 3'd0, 5'd1, 5'd2);
      #1;
      check($sformatf("stall%0d_valid", c), out_valid, 1);
      if (sb.size() > 0) check($sformatf("stall%0d_hold", c), dut_bundle(), sb[0]);
      check($sformatf("stall%0d_ready", c), in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    expect_out("stall");
    retire(S_REGS, 5'd15);

    // Flush: r22 left busy, flushed r21 write must not mark r21 busy
    @(negedge clk);
    offer(enc_r(OP_ADD, 0, 0, 5'd22, 3'd0, 5'd1, 5'd2), exp_add(5'd22, 5'd1, 5'd2), "fl_w22");
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("fl_w22");
    @(negedge clk);
    out_ready = 1'b0;
    offer(enc_r(OP_ADD, 0, 0, 5'd21, 3'd0, 5'd1, 5'd2), exp_add(5'd21, 5'd1, 5'd2), "fl_w21");
    @(negedge clk);
    check("fl_held", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    in_inst = enc_r(OP_AND, 0, 0, 5'd23, 3'd0, 5'd1, 5'd2);
    #1;
    check("fl_blocks", in_ready, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_clears_valid", out_valid, 0);
    @(negedge clk);
    offer(enc_r(OP_ADD, 0, 0, 5'd24, 3'd0, 5'd21, 5'd1), exp_add(5'd24, 5'd21, 5'd1), "fl_no_set");
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("fl_no_set");
    retire(S_REGS, 5'd24);
    @(negedge clk);
    in_valid = 1'b1; in_inst = enc_r(OP_ADD, 0, 0, 5'd25, 3'd0, 5'd22, 5'd1);
    #1;
    check("fl_keeps_busy", in_ready, 0);
    in_valid = 1'b0;

    // Reset mid-transfer drops the held bundle and clears r22 busy
    @(negedge clk);
    out_ready = 1'b0;
    offer(enc_r(OP_ADD, 0, 0, 5'd27, 3'd0, 5'd1, 5'd2), exp_add(5'd27, 5'd1, 5'd2), "mid_w27");
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("mid_w27");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_fields", dut_bundle(), exp_t'(0));
    @(negedge clk);
    offer(enc_r(OP_ADD, 0, 0, 5'd25, 3'd0, 5'd22, 5'd1), exp_add(5'd25, 5'd22, 5'd1), "rst_clr_busy");
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("rst_clr_busy");
    retire(S_REGS, 5'd25);

    // HALT: emitted with out_halted, then acceptance blocked until reset
    @(negedge clk);
    offer(enc_r(OP_HALT, 0, 0, 5'd0, 3'd0, 5'd0, 5'd0),
          mk(OP_HALT, 3'b010, 3'd0, 5'b01010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0), "halt");
    @(negedge clk);
    in_inst = enc_r(OP_AND, 0, 0, 5'd26, 3'd0, 5'd1, 5'd2);
    #1;
    expect_out("halt");
    check("halt_latched", halt_latched, 1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("halt_blocks%0d", c), in_ready, 0);
      @(negedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("halt_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("halt_rst_latched", halt_latched, 0);
    check("halt_rst_valid", out_valid, 0);
    check("halt_rst_ready_after", in_ready, 1);
    in_valid = 1'b0;
    check("sb_drained", sb.size(), 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
